// File: rtl/syn_hazard_resolver_if.sv
// ID-stage / detector / hazard-control bundle seen by the hazard resolver.
// No storage; the bundle carries only signals, so it adds no latency.
// No handshake: the control outputs gate the pipeline, and the detector follows pipe_en.
interface syn_hazard_resolver_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_req_a;
  logic [4:0]       id_req_b;
  logic             id_use_a;
  logic             id_use_b;
  logic             id_wen;
  logic             id_is_load;
  logic             id_mem;
  logic             ex_collision_a;
  logic             dm_collision_a;
  logic             ex_collision_b;
  logic             dm_collision_b;
  logic             branch_taken;
  logic             dm_ready;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_en;
  logic             detector_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: drives ID/detector/memory status, observes hazard controls.
  modport master (
    output id_req_a, id_req_b, id_use_a, id_use_b, id_wen, id_is_load, id_mem,
    output ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b,
    output branch_taken, dm_ready,
    input  fwd_a_sel, fwd_b_sel, pc_en, ifid_en, ifid_flush, idex_bubble,
    input  pipe_en, detector_en, stall_cnt, flush_cnt
  );

  // Resolver side.
  modport slave (
    input  id_req_a, id_req_b, id_use_a, id_use_b, id_wen, id_is_load, id_mem,
    input  ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b,
    input  branch_taken, dm_ready,
    output fwd_a_sel, fwd_b_sel, pc_en, ifid_en, ifid_flush, idex_bubble,
    output pipe_en, detector_en, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/syn_hazard_resolver.sv
// Turns detector collision flags into forwarding selects, load-use stalls, branch flushes, memory-wait freezes.
// Forwarding and control are combinational in the same cycle; the counters update on the event-cycle edge.
// A data-memory wait freezes the whole pipe. A load-use stall holds PC/IF-ID and bubbles ID/EX.
module syn_hazard_resolver #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  syn_hazard_resolver_if.slave hz
);

  // EX/DM history of the instructions in flight. This mirrors the collision detector's own history.
  logic ex_v, ex_wen, ex_ld, ex_mem;
  logic dm_v, dm_wen, dm_mem;

  logic exh_a, exh_b, dmh_a, dmh_b;
  logic mem_wait, lu_hazard;
  logic stall_evt, flush_evt;

  logic             pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // A hit only counts when the ID instruction really reads the source and the older instruction writes.
  // r0 is excluded, so the detector's zeroed reset state can never produce a hit.
  assign exh_a = hz.ex_collision_a & hz.id_use_a & ex_v & ex_wen & (hz.id_req_a != 5'd0);
  assign exh_b = hz.ex_collision_b & hz.id_use_b & ex_v & ex_wen & (hz.id_req_b != 5'd0);
  assign dmh_a = hz.dm_collision_a & hz.id_use_a & dm_v & dm_wen & (hz.id_req_a != 5'd0);
  assign dmh_b = hz.dm_collision_b & hz.id_use_b & dm_v & dm_wen & (hz.id_req_b != 5'd0);

  assign mem_wait  = dm_v & dm_mem & ~hz.dm_ready;
  assign lu_hazard = (exh_a | exh_b) & ex_ld;

  // A counter event needs the pipe to actually move. A memory wait therefore masks both counters.
  assign flush_evt = rst & ~mem_wait & hz.branch_taken;
  assign stall_evt = rst & ~mem_wait & ~hz.branch_taken & lu_hazard;

  // Advance the EX/DM history whenever the pipe registers load. A bubble enters EX as an empty slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v   <= 1'b0;
      ex_wen <= 1'b0;
      ex_ld  <= 1'b0;
      ex_mem <= 1'b0;
      dm_v   <= 1'b0;
      dm_wen <= 1'b0;
      dm_mem <= 1'b0;
    end else if (pipe_en) begin
      ex_v   <= ~idex_bubble;
      ex_wen <= hz.id_wen     & ~idex_bubble;
      ex_ld  <= hz.id_is_load & ~idex_bubble;
      ex_mem <= hz.id_mem     & ~idex_bubble;
      dm_v   <= ex_v;
      dm_wen <= ex_wen;
      dm_mem <= ex_mem;
    end
  end

  // Priority control: memory wait freezes everything, then branch flush, then load-use stall, then run.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b0;
    if (!rst || mem_wait) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (hz.branch_taken) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_en     = 1'b1;
    end else if (lu_hazard) begin
      idex_bubble = 1'b1;
      pipe_en     = 1'b1;
    end else begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      pipe_en = 1'b1;
    end
  end

  // Forwarding selects: the youngest producer (EX) wins over DM.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (rst) begin
      if (exh_a)      fwd_a_sel = 2'b01;
      else if (dmh_a) fwd_a_sel = 2'b10;
      if (exh_b)      fwd_b_sel = 2'b01;
      else if (dmh_b) fwd_b_sel = 2'b10;
    end
  end

  // Saturating event counters. They stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.fwd_a_sel   = fwd_a_sel;
  assign hz.fwd_b_sel   = fwd_b_sel;
  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.pipe_en     = pipe_en;
  assign hz.detector_en = pipe_en;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_syn_hazard_resolver.sv
// Bench for syn_hazard_resolver: directed hazard scenarios followed by random traffic.
// The reference model tracks in-flight instructions as records and predicts every output each cycle.
// A narrow counter width keeps counter saturation reachable in a short run.
module tb_syn_hazard_resolver;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  syn_hazard_resolver_if #(.CNT_W(CNT_W)) hz ();
  syn_hazard_resolver #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz.slave));

  typedef struct {bit v; bit wen; bit ld; bit mem;} instr_t;
  typedef struct {int fa; int fb; bit pc; bit ifid; bit fl; bit bb; bit pipe; bit st; bit fe;} exp_t;

  // inflight[0] is the instruction in EX; inflight[1] is the instruction in DM.
  instr_t inflight [2];
  int     m_stall, m_flush;
  exp_t   cur;
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic instr_t mk(input bit v, input bit wen, input bit ld, input bit mem);
    instr_t r;
    r.v = v; r.wen = wen; r.ld = ld; r.mem = mem;
    return r;
  endfunction

  // Predict the outputs from the rules: valid hits, priority of wait/flush/stall/run.
  function automatic exp_t predict();
    exp_t e;
    bit ha_ex, hb_ex, ha_dm, hb_dm;
    ha_ex = hz.ex_collision_a && hz.id_use_a && inflight[0].v && inflight[0].wen && (hz.id_req_a != 0);
    hb_ex = hz.ex_collision_b && hz.id_use_b && inflight[0].v && inflight[0].wen && (hz.id_req_b != 0);
    ha_dm = hz.dm_collision_a && hz.id_use_a && inflight[1].v && inflight[1].wen && (hz.id_req_a != 0);
    hb_dm = hz.dm_collision_b && hz.id_use_b && inflight[1].v && inflight[1].wen && (hz.id_req_b != 0);
    e.fa = ha_ex ? 1 : (ha_dm ? 2 : 0);
    e.fb = hb_ex ? 1 : (hb_dm ? 2 : 0);
    e.pc = 1; e.ifid = 1; e.fl = 0; e.bb = 0; e.pipe = 1; e.st = 0; e.fe = 0;
    if (!rst) begin
      e.fa = 0; e.fb = 0; e.pc = 0; e.ifid = 0; e.pipe = 0;
    end else if (inflight[1].v && inflight[1].mem && !hz.dm_ready) begin
      e.pc = 0; e.ifid = 0; e.pipe = 0;
    end else if (hz.branch_taken) begin
      e.fl = 1; e.bb = 1; e.fe = 1;
    end else if ((ha_ex || hb_ex) && inflight[0].ld) begin
      e.pc = 0; e.ifid = 0; e.bb = 1; e.st = 1;
    end
    return e;
  endfunction

  always_comb cur = predict();

  // Reference model state update: shift the instructions on pipe advance and count events with saturation.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight[0] <= mk(0, 0, 0, 0);
      inflight[1] <= mk(0, 0, 0, 0);
      m_stall     <= 0;
      m_flush     <= 0;
    end else begin
      if (cur.pipe) begin
        inflight[1] <= inflight[0];
        inflight[0] <= cur.bb ? mk(0, 0, 0, 0) : mk(1, hz.id_wen, hz.id_is_load, hz.id_mem);
      end
      if (cur.st && m_stall < SAT) m_stall <= m_stall + 1;
      if (cur.fe && m_flush < SAT) m_flush <= m_flush + 1;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model. Call this shortly after inputs change, well away from posedge.
  task automatic step(input string tag);
    #1;
    check_val({tag, ".fwd_a"}, int'(hz.fwd_a_sel), cur.fa);
    check_val({tag, ".fwd_b"}, int'(hz.fwd_b_sel), cur.fb);
    check_val({tag, ".pc_en"}, int'(hz.pc_en), int'(cur.pc));
    check_val({tag, ".ifid_en"}, int'(hz.ifid_en), int'(cur.ifid));
    check_val({tag, ".flush"}, int'(hz.ifid_flush), int'(cur.fl));
    check_val({tag, ".bubble"}, int'(hz.idex_bubble), int'(cur.bb));
    check_val({tag, ".pipe_en"}, int'(hz.pipe_en), int'(cur.pipe));
    check_val({tag, ".det_en"}, int'(hz.detector_en), int'(cur.pipe));
    check_val({tag, ".stall_cnt"}, int'(hz.stall_cnt), m_stall);
    check_val({tag, ".flush_cnt"}, int'(hz.flush_cnt), m_flush);
  endtask

  task automatic clr();
    hz.id_req_a = 5'd0; hz.id_req_b = 5'd0; hz.id_use_a = 1'b0; hz.id_use_b = 1'b0;
    hz.id_wen = 1'b0; hz.id_is_load = 1'b0; hz.id_mem = 1'b0;
    hz.ex_collision_a = 1'b0; hz.dm_collision_a = 1'b0;
    hz.ex_collision_b = 1'b0; hz.dm_collision_b = 1'b0;
    hz.branch_taken = 1'b0; hz.dm_ready = 1'b1;
  endtask

  task automatic drive_id(input int ra, input int rb, input bit ua, input bit ub,
                          input bit wen, input bit ld, input bit mem);
    hz.id_req_a = 5'(ra); hz.id_req_b = 5'(rb); hz.id_use_a = ua; hz.id_use_b = ub;
    hz.id_wen = wen; hz.id_is_load = ld; hz.id_mem = mem;
  endtask

  task automatic drive_det(input bit exa, input bit dma, input bit exb, input bit dmb);
    hz.ex_collision_a = exa; hz.dm_collision_a = dma;
    hz.ex_collision_b = exb; hz.dm_collision_b = dmb;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    // Reset asserted while the collision flags are high.
    @(negedge clk); drive_det(1, 1, 1, 1); drive_id(3, 3, 1, 1, 1, 0, 0); step("rst");
    check_val("rst.pc_en_zero", int'(hz.pc_en), 0);

    // After reset: r0 source with every flag high produces no hit.
    @(negedge clk); rst = 1'b1; clr(); drive_id(0, 0, 1, 1, 1, 0, 0); drive_det(1, 1, 1, 1); step("r0_post_rst");
    check_val("r0_post_rst.fwd_a_zero", int'(hz.fwd_a_sel), 0);

    // add r3, then add r4,r3: forward from EX.
    @(negedge clk); clr(); drive_id(1, 2, 1, 1, 1, 0, 0); step("add1");
    @(negedge clk); clr(); drive_id(3, 0, 1, 0, 1, 0, 0); drive_det(1, 0, 0, 0); step("add2");
    check_val("add2.fwd_a_ex", int'(hz.fwd_a_sel), 1);
    check_val("add2.no_stall", int'(hz.pc_en), 1);

    // lw r5, then add r6,r5,r5: one stall cycle, then forwarding from DM.
    @(negedge clk); clr(); drive_id(1, 0, 1, 0, 1, 1, 1); step("lw");
    @(negedge clk); clr(); drive_id(5, 5, 1, 1, 1, 0, 0); drive_det(1, 0, 1, 0); step("lu_stall");
    check_val("lu_stall.bubble", int'(hz.idex_bubble), 1);
    check_val("lu_stall.pc_en", int'(hz.pc_en), 0);
    @(negedge clk); drive_det(0, 1, 0, 1); step("lu_after");
    check_val("lu_after.fwd_a_dm", int'(hz.fwd_a_sel), 2);
    check_val("lu_after.fwd_b_dm", int'(hz.fwd_b_sel), 2);
    check_val("lu_after.stall_cnt", int'(hz.stall_cnt), 1);

    // r0 source while a writer sits in both EX and DM.
    @(negedge clk); clr(); drive_id(0, 0, 1, 1, 1, 0, 0); drive_det(1, 1, 1, 1); step("r0_busy");
    check_val("r0_busy.fwd_b_zero", int'(hz.fwd_b_sel), 0);

    // sw reaches DM, then memory is not ready for 3 cycles.
    @(negedge clk); clr(); drive_id(1, 2, 1, 1, 0, 0, 1); step("sw");
    @(negedge clk); clr(); step("sw_nop");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clr(); hz.dm_ready = 1'b0; step("memwait");
      check_val("memwait.pipe_en", int'(hz.pipe_en), 0);
    end
    @(negedge clk); clr(); step("memdone");
    check_val("memdone.pc_en", int'(hz.pc_en), 1);

    // A taken branch coincides with a load-use hazard: the flush wins.
    @(negedge clk); clr(); drive_id(1, 0, 1, 0, 1, 1, 1); step("br_lw");
    @(negedge clk); clr(); drive_id(7, 0, 1, 0, 1, 0, 0); drive_det(1, 0, 0, 0); hz.branch_taken = 1'b1; step("br_lu");
    check_val("br_lu.flush", int'(hz.ifid_flush), 1);
    check_val("br_lu.pc_en", int'(hz.pc_en), 1);
    @(negedge clk); clr(); step("br_after");
    check_val("br_after.stall_cnt", int'(hz.stall_cnt), 1);
    check_val("br_after.flush_cnt", int'(hz.flush_cnt), 1);

    // Repeated load-use stalls drive stall_cnt into saturation.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); clr(); drive_id(1, 0, 1, 0, 1, 1, 1); step("sat_lw");
      @(negedge clk); clr(); drive_id(9, 0, 1, 0, 1, 0, 0); drive_det(1, 0, 0, 0); step("sat_lu");
    end
    @(negedge clk); clr(); step("sat_end");
    check_val("sat_end.stall_cnt", int'(hz.stall_cnt), SAT);

    // Reset asserted mid-stall clears everything immediately.
    @(negedge clk); clr(); drive_id(1, 0, 1, 0, 1, 1, 1); step("mr_lw");
    @(negedge clk); clr(); drive_id(9, 0, 1, 0, 1, 0, 0); drive_det(1, 0, 0, 0); step("mr_stall");
    rst = 1'b0; step("mr_rst");
    check_val("mr_rst.stall_cnt", int'(hz.stall_cnt), 0);
    check_val("mr_rst.bubble", int'(hz.idex_bubble), 0);
    @(negedge clk); rst = 1'b1; step("mr_release");
    check_val("mr_release.no_hit", int'(hz.pc_en), 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = ($urandom_range(99) != 0);
      drive_id($urandom_range(31), $urandom_range(31), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      drive_det(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      hz.branch_taken = ($urandom_range(7) == 0);
      hz.dm_ready     = ($urandom_range(3) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
